// File: rtl/ram_async_pkg.sv
// ram_async_pkg: shared types for the async RAM initiator.
// FSM state encoding and default bus widths.
`timescale 1ns/1ps
package ram_async_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_async_master.sv
// ram_async_master: clocked initiator for an asynchronous RAM port.
// Ports: clk/rst_n, req_* command channel, rsp_* response channel, ram_* RAM pins.
`timescale 1ns/1ps
module ram_async_master
  import ram_async_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_dout
);

  // First beat counts WAIT-1..0; later burst beats get one
  // extra cycle so the new address settles after the hold.
  localparam logic [3:0] W_FIRST = 4'(WAIT - 1);
  localparam logic [3:0] W_NEXT  = 4'(WAIT);

  state_t     state;
  logic [3:0] wcnt;
  logic [3:0] rem;
  logic       wr_q;

  assign req_ready = rst_n && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      rem       <= '0;
      wr_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_wr    <= 1'b0;
      ram_en    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state    <= ST_SETUP;
            ram_en   <= 1'b1;
            ram_addr <= req_addr;
            ram_din  <= req_wdata;
            wr_q     <= req_wr;
            rem      <= req_wr ? 4'd0 : req_len;
            wcnt     <= W_FIRST;
          end
        end
        ST_SETUP: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else if (wr_q) begin
            ram_wr <= 1'b1;
            state  <= ST_STROBE;
          end else begin
            rsp_rdata <= ram_dout;
            rsp_wr    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_STROBE: begin
          ram_wr    <= 1'b0;
          rsp_rdata <= '0;
          rsp_wr    <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!wr_q && rem != 4'd0) begin
              rem      <= rem - 4'd1;
              ram_addr <= ram_addr + ADDR_W'(1);
              wcnt     <= W_NEXT;
              state    <= ST_SETUP;
            end else begin
              ram_en <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_async_master.sv
// tb_ram_async_master: directed bench, two masters (WAIT=1, WAIT=3)
// each driving its own behavioural async RAM.
`timescale 1ns/1ps
module tb_ram_async_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_wr = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [3:0] req_len = '0;
  logic       rsp_ready = 1'b1;

  logic       rr0, rv0, rw0, mw0, me0;
  logic [7:0] rd0, ma0, md0, dout0;
  logic       rr3, rv3, rw3, mw3, me3;
  logic [7:0] rd3, ma3, md3, dout3;
  logic [7:0] mem0 [256];
  logic [7:0] mem3 [256];

  logic       req_ready, rsp_valid, rsp_wr, ram_wr, ram_en;
  logic [7:0] rsp_rdata, ram_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_async_master #(.ADDR_W(8), .DATA_W(8), .WAIT(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(rr0),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_wr(rw0), .rsp_rdata(rd0),
    .ram_addr(ma0), .ram_din(md0),
    .ram_wr(mw0), .ram_en(me0), .ram_dout(dout0)
  );

  ram_async_master #(.ADDR_W(8), .DATA_W(8), .WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(rr3),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rv3), .rsp_ready(rsp_ready),
    .rsp_wr(rw3), .rsp_rdata(rd3),
    .ram_addr(ma3), .ram_din(md3),
    .ram_wr(mw3), .ram_en(me3), .ram_dout(dout3)
  );

  // Async RAM models: write completes at the end of the wr pulse.
  assign dout0 = me0 ? mem0[ma0] : 8'hzz;
  assign dout3 = me3 ? mem3[ma3] : 8'hzz;
  always @(negedge mw0) mem0[ma0] = md0;
  always @(negedge mw3) mem3[ma3] = md3;

  assign req_ready = sel ? rr3 : rr0;
  assign rsp_valid = sel ? rv3 : rv0;
  assign rsp_wr    = sel ? rw3 : rw0;
  assign rsp_rdata = sel ? rd3 : rd0;
  assign ram_addr  = sel ? ma3 : ma0;
  assign ram_wr    = sel ? mw3 : mw0;
  assign ram_en    = sel ? me3 : me0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic [3:0] len);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_len   = len;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    tick();
    req_valid = 1'b0;
  endtask

  // k=0 is the cycle starting at the accept/handshake edge.
  task automatic wait_rsp(output int lat, output int wr_at,
                          output int wr_n);
    lat = -1;
    wr_at = -1;
    wr_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (ram_wr) begin
        wr_n++;
        if (wr_at < 0) wr_at = k;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || ram_en !== 1'b0 ||
        ram_wr !== 1'b0 || ram_addr !== 8'd0 || rsp_rdata !== 8'd0 ||
        rsp_wr !== 1'b0 || md0 !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_vals: rdy=%b vld=%b en=%b wr=%b addr=%0d rd=%0d rw=%b din=%0d want all 0",
               req_ready, rsp_valid, ram_en, ram_wr, ram_addr,
               rsp_rdata, rsp_wr, md0);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rr3 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b/%b want 1/1", req_ready, rr3);
    end
  endtask

  task automatic test_write();
    int lat, wa, wn;
    logic [7:0] av [2];
    logic [7:0] dv [2];
    av[0] = 8'd1;  dv[0] = 8'd15;
    av[1] = 8'd10; dv[1] = 8'd120;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, av[i], dv[i], 4'd0);
      wait_rsp(lat, wa, wn);
      n_cmp++;
      if (lat !== 2 || wa !== 1 || wn !== 1) begin
        n_bad++;
        $display("FAIL write_timing[%0d]: lat=%0d wr_at=%0d wr_n=%0d want 2/1/1",
                 i, lat, wa, wn);
      end
      n_cmp++;
      if (rsp_wr !== 1'b1 || rsp_rdata !== 8'd0) begin
        n_bad++;
        $display("FAIL write_ack[%0d]: rsp_wr=%b rdata=%0d want 1/0",
                 i, rsp_wr, rsp_rdata);
      end
      tick();
      n_cmp++;
      if (mem0[av[i]] !== dv[i]) begin
        n_bad++;
        $display("FAIL write_mem[%0d]: got %0d want %0d", i, mem0[av[i]], dv[i]);
      end
    end
  endtask

  task automatic test_read_single();
    int lat, wa, wn;
    issue(1'b0, 8'd1, 8'd0, 4'd0);
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 1 || rsp_rdata !== 8'd15 || rsp_wr !== 1'b0 || wn !== 0) begin
      n_bad++;
      $display("FAIL read_single: lat=%0d rdata=%0d rsp_wr=%b wr_n=%0d want 1/15/0/0",
               lat, rsp_rdata, rsp_wr, wn);
    end
    tick();
    n_cmp++;
    if (ram_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL read_single_idle: en=%b rdy=%b vld=%b want 0/1/0",
               ram_en, req_ready, rsp_valid);
    end
  endtask

  task automatic test_wrap();
    int lat, wa, wn;
    issue(1'b1, 8'd255, 8'd99, 4'd0);
    wait_rsp(lat, wa, wn);
    tick();
    issue(1'b1, 8'd0, 8'd7, 4'd0);
    wait_rsp(lat, wa, wn);
    tick();
    issue(1'b0, 8'd255, 8'd0, 4'd1);
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 1 || rsp_rdata !== 8'd99 || ram_addr !== 8'd255) begin
      n_bad++;
      $display("FAIL wrap_beat0: lat=%0d rdata=%0d addr=%0d want 1/99/255",
               lat, rsp_rdata, ram_addr);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_gap: vld=%b rdy=%b want 0/0", rsp_valid, req_ready);
    end
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 2 || rsp_rdata !== 8'd7 || ram_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_beat1: lat=%0d rdata=%0d addr=%0d want 2/7/0",
               lat, rsp_rdata, ram_addr);
    end
    tick();
    n_cmp++;
    if (ram_en !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_end: en=%b rdy=%b want 0/1", ram_en, req_ready);
    end
  endtask

  task automatic test_stall();
    int lat, wa, wn;
    int bad;
    rsp_ready = 1'b0;
    issue(1'b0, 8'd0, 8'd0, 4'd1);
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 1 || rsp_rdata !== 8'd7) begin
      n_bad++;
      $display("FAIL stall_first: lat=%0d rdata=%0d want 1/7", lat, rsp_rdata);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'd7 ||
          ram_addr !== 8'd0 || req_ready !== 1'b0 || rsp_wr !== 1'b0)
        bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL stall_hold: %0d unstable cycles want 0", bad);
    end
    rsp_ready = 1'b1;
    tick();
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 2 || rsp_rdata !== 8'd15 || ram_addr !== 8'd1) begin
      n_bad++;
      $display("FAIL stall_beat1: lat=%0d rdata=%0d addr=%0d want 2/15/1",
               lat, rsp_rdata, ram_addr);
    end
    tick();
  endtask

  task automatic test_wait3();
    int lat, wa, wn;
    sel = 1'b1;
    #1;
    issue(1'b1, 8'd50, 8'h5A, 4'd0);
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 4 || wa !== 3 || wn !== 1 || rsp_wr !== 1'b1) begin
      n_bad++;
      $display("FAIL wait3_write: lat=%0d wr_at=%0d wr_n=%0d rsp_wr=%b want 4/3/1/1",
               lat, wa, wn, rsp_wr);
    end
    tick();
    issue(1'b0, 8'd50, 8'd0, 4'd0);
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 3 || rsp_rdata !== 8'h5A || rsp_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL wait3_read: lat=%0d rdata=%h rsp_wr=%b want 3/5a/0",
               lat, rsp_rdata, rsp_wr);
    end
    tick();
    sel = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    int lat, wa, wn;
    int seen;
    issue(1'b1, 8'd20, 8'h33, 4'd0);
    seen = 0;
    for (int i = 0; i < 20 && !ram_wr; i++) tick();
    n_cmp++;
    if (ram_wr !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_strobe: ram_wr=%b want 1", ram_wr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ram_wr !== 1'b0 || ram_en !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: wr=%b en=%b vld=%b want 0/0/0",
               ram_wr, ram_en, rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (rsp_valid) seen++;
      tick();
    end
    n_cmp++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_noack: ack cycles=%0d rdy=%b want 0/1", seen, req_ready);
    end
    issue(1'b0, 8'd10, 8'd0, 4'd0);
    wait_rsp(lat, wa, wn);
    n_cmp++;
    if (lat !== 1 || rsp_rdata !== 8'd120) begin
      n_bad++;
      $display("FAIL rst_mid_readback: lat=%0d rdata=%0d want 1/120",
               lat, rsp_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_single();
    test_wrap();
    test_stall();
    test_wait3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
